// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, defaults and sizing helper for the parametrised FIFO
//
// Purpose: common definitions imported by fifo_ram and sync_fifo_param.
// Contents:
//   ptr_w()        pointer width for a given depth (address bits + wrap bit)
//   fifo_status_t  registered status flags of the FIFO
//   STATUS_RST     status value held while in reset
//   DATA_W_DEF / DEPTH_DEF  default geometry

package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  // One extra bit above the address so full and empty can be told apart
  // when the read and write addresses coincide.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - register-array storage with one sync write and one async read port
//
// Purpose: data storage for sync_fifo_param; contents are never reset.
// Ports:
//   clk    in   1          clock, rising edge
//   we     in   1          write strobe
//   waddr  in   ADDR_W     write address
//   wdata  in   DATA_W     write data
//   raddr  in   ADDR_W     read address
//   rdata  out  DATA_W     read data, combinational from raddr

module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-2:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-2:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with flags, count and error pulses
//
// Purpose: rate/latency buffer between a producer and a consumer in one clock domain.
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through output
//   (data_out shows the head word combinationally, read_enable pops it);
//   undefined gives a registered data_out loaded one cycle after an accepted read.
// Ports:
//   clk           in   1               clock, rising edge
//   reset         in   1               asynchronous, active-high reset
//   write_enable  in   1               write request
//   data_in       in   DATA_W          write data
//   read_enable   in   1               read request / pop
//   data_out      out  DATA_W          read data
//   full          out  1               count == DEPTH
//   empty         out  1               count == 0
//   almost_full   out  1               count >= AFULL_TH
//   almost_empty  out  1               count <= AEMPTY_TH
//   count         out  $clog2(DEPTH)+1 occupancy 0..DEPTH
//   overflow      out  1               pulse: write was rejected last cycle
//   underflow     out  1               pulse: read was rejected last cycle

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   read_enable,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0]  count_q, count_nxt;
  fifo_status_t      status_q, status_nxt;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rdata;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = read_enable & ~status_q.empty;
  assign wr_acc = write_enable & (~status_q.full | rd_acc);

  always_comb begin
    wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);
    rd_ptr_nxt = rd_ptr + PTR_W'(rd_acc);

    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase

    // Flags are computed from next-state values so that, once registered,
    // they line up with count on the same edge.
    status_nxt.full         = (wr_ptr_nxt[PTR_W-1] != rd_ptr_nxt[PTR_W-1]) &&
                              (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
    status_nxt.empty        = (wr_ptr_nxt == rd_ptr_nxt);
    status_nxt.almost_full  = (count_nxt >= AFULL_C);
    status_nxt.almost_empty = (count_nxt <= AEMPTY_C);
    status_nxt.overflow     = write_enable & ~wr_acc;
    status_nxt.underflow    = read_enable & status_q.empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      status_q <= STATUS_RST;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count_q  <= count_nxt;
      status_q <= status_nxt;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; meaningless while empty.
  assign data_out = ram_rdata;
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= ram_rdata;
    end
  end

  assign data_out = dout_q;
`endif

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param (registered-output build)

module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = DEPTH - 2;
  localparam int AEMPTY = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              write_enable = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              read_enable = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]        count;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_dout = '0;

  sync_fifo_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL),
    .AEMPTY_TH (AEMPTY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input logic exp_ovf, input logic exp_udf);
    int n;
    n = sb_q.size();
    check_val("count", 32'(count), 32'(n));
    check_val("empty", 32'(empty), 32'(n == 0));
    check_val("full", 32'(full), 32'(n == DEPTH));
    check_val("almost_full", 32'(almost_full), 32'(n >= AFULL));
    check_val("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
    check_val("overflow", 32'(overflow), 32'(exp_ovf));
    check_val("underflow", 32'(underflow), 32'(exp_udf));
    check_val("data_out", 32'(data_out), 32'(exp_dout));
  endtask

  // Drive one cycle of requests; acceptance is predicted from the scoreboard
  // occupancy before the edge, then every output is checked #1 after it.
  task automatic step(input logic we, input logic re, input logic [DATA_W-1:0] din);
    logic rd_acc, wr_acc;
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    rd_acc = re && (sb_q.size() != 0);
    wr_acc = we && ((sb_q.size() < DEPTH) || rd_acc);
    @(posedge clk);
    if (rd_acc) exp_dout = sb_q.pop_front();
    if (wr_acc) sb_q.push_back(din);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check_state(we && !wr_acc, re && !rd_acc && (sb_q.size() == 0 || !rd_acc) && re && !rd_acc);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    sb_q.delete();
    exp_dout = '0;
    check_state(1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_state(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // 1: reset state and idle stability
    @(posedge clk);
    #1;
    pulse_reset();
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // 2: three writes then three reads
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'hCC);
    step(1'b1, 1'b0, 8'h0F);
    repeat (3) step(1'b0, 1'b1, 8'h00);

    // 3: fill, overflow on the 17th write, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hAA);
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    // 4: read while empty, then write+read on empty
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'h00);

    // 5: full with simultaneous write and read
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    // 6: reset mid-burst, next write is first out
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hE0 + i));
    pulse_reset();
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);

    // 7: interleaved traffic across several pointer wraps
    for (int i = 0; i < 120; i++)
      step(($urandom_range(0, 3) != 0), ((i % 3) != 0) || ($urandom_range(0, 1) == 1),
           8'($urandom_range(0, 255)));
    while (sb_q.size() != 0) step(1'b0, 1'b1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
